// File: rtl/game_pkg.sv
// Shared types and helpers for the memory-game controller.
// State codes and player-count decode.
package game_pkg;

  localparam int TIMER_W = 32;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_FLIP = 3'd1,
    S_COMPARE   = 3'd2,
    S_EVAL      = 3'd3,
    S_HOLD      = 3'd4,
    S_MOVE      = 3'd5,
    S_NEXT      = 3'd6,
    S_OVER      = 3'd7
  } state_t;

  function automatic logic [2:0] num_players(
    input logic [1:0] n
  );
    logic [2:0] p;
    if (n == 2'd0) p = 3'd2;
    else           p = {1'b0, n} + 3'd1;
    return p;
  endfunction

  function automatic logic [1:0] next_player(
    input logic [1:0] cur,
    input logic [1:0] n
  );
    logic [2:0] inc;
    logic [1:0] res;
    inc = {1'b0, cur} + 3'd1;
    if (inc >= num_players(n)) res = 2'd0;
    else                       res = inc[1:0];
    return res;
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Loadable 32-bit down-counter with zero flag.
// Holds at zero rather than wrapping.
module turn_timer
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               enable,
  input  logic [TIMER_W-1:0] load_value,
  output logic [TIMER_W-1:0] value,
  output logic               zero
);

  logic [TIMER_W-1:0] cnt;

  // load wins over count; count stops at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign value = cnt;
  assign zero  = (cnt == '0);

endmodule

// File: rtl/game_controller.sv
// Turn-sequencing FSM for the memory game.
// Strobes A/B/next_turn drive the external datapath.
module game_controller
  import game_pkg::*;
#(
  parameter int REVEAL_CYCLES = 25000000,
  parameter int TURN_TIMEOUT  = 500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       flip,
  input  logic [3:0] card_sel,
  input  logic [1:0] N,
  input  logic       go,
  input  logic       W,
  output logic       A,
  output logic       B,
  output logic       statecombo_next_turn,
  output logic [3:0] position_data,
  output logic [1:0] cur_player,
  output logic       reveal,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam logic [TIMER_W-1:0] REV_LOAD =
    TIMER_W'(REVEAL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TURN_LOAD =
    TIMER_W'(TURN_TIMEOUT);

  state_t st, nxt;

  logic match;
  logic turn_ld, turn_en, turn_zero;
  logic rev_ld, rev_en, rev_zero;
  logic lat_pos, clr_player, adv_player;
  logic lat_match, lat_winner;
  logic [TIMER_W-1:0] turn_val, rev_val;
  logic unused_timer_bits;

  assign unused_timer_bits = ^{turn_val, rev_val};

  turn_timer u_turn (
    .clk        (clk),
    .rst        (rst),
    .load       (turn_ld),
    .enable     (turn_en),
    .load_value (TURN_LOAD),
    .value      (turn_val),
    .zero       (turn_zero)
  );

  turn_timer u_reveal (
    .clk        (clk),
    .rst        (rst),
    .load       (rev_ld),
    .enable     (rev_en),
    .load_value (REV_LOAD),
    .value      (rev_val),
    .zero       (rev_zero)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= S_IDLE;
    else      st <= nxt;
  end

  // next state, strobes and datapath enables
  always_comb begin
    nxt                  = st;
    A                    = 1'b0;
    B                    = 1'b0;
    statecombo_next_turn = 1'b0;
    reveal               = 1'b0;
    turn_ld              = 1'b0;
    turn_en              = 1'b0;
    rev_ld               = 1'b0;
    rev_en               = 1'b0;
    lat_pos              = 1'b0;
    clr_player           = 1'b0;
    adv_player           = 1'b0;
    lat_match            = 1'b0;
    lat_winner           = 1'b0;
    unique case (st)
      S_IDLE, S_OVER: begin
        if (start) begin
          clr_player = 1'b1;
          turn_ld    = 1'b1;
          nxt        = S_WAIT_FLIP;
        end
      end
      S_WAIT_FLIP: begin
        if (flip) begin
          lat_pos = 1'b1;
          nxt     = S_COMPARE;
        end else if (turn_zero) begin
          nxt = S_NEXT;
        end else begin
          turn_en = 1'b1;
        end
      end
      S_COMPARE: begin
        A      = 1'b1;
        reveal = 1'b1;
        nxt    = S_EVAL;
      end
      S_EVAL: begin
        reveal    = 1'b1;
        lat_match = 1'b1;
        rev_ld    = 1'b1;
        nxt       = S_HOLD;
      end
      S_HOLD: begin
        reveal = 1'b1;
        if (rev_zero) nxt = match ? S_MOVE : S_NEXT;
        else          rev_en = 1'b1;
      end
      S_MOVE: begin
        B = 1'b1;
        if (W) begin
          lat_winner = 1'b1;
          nxt        = S_OVER;
        end else begin
          turn_ld = 1'b1;
          nxt     = S_WAIT_FLIP;
        end
      end
      S_NEXT: begin
        statecombo_next_turn = 1'b1;
        adv_player           = 1'b1;
        turn_ld              = 1'b1;
        nxt                  = S_WAIT_FLIP;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // game datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      position_data <= '0;
      cur_player    <= '0;
      winner        <= '0;
      match         <= 1'b0;
    end else begin
      if (lat_pos)    position_data <= card_sel;
      if (lat_match)  match         <= go;
      if (lat_winner) winner        <= cur_player;
      if (clr_player) cur_player    <= '0;
      else if (adv_player)
        cur_player <= next_player(cur_player, N);
    end
  end

  assign game_over = (st == S_OVER);
  assign state     = st;

endmodule
